pixel_stream_packer: RTL and testbench
======================================

# pixel_stream_packer

Packs a stream of 24-bit RGB pixels into 32-bit AXI-Stream video words (4 pixels → 3 words) and generates frame/line framing: `tuser` on the first word of each frame, `tlast` on the last word of each line. It sits between a per-pixel source (fractal renderer core) and the VDMA-facing `out_stream_*` port. It is the transmitter that the stream checker bench receives from.

## Interface
- `X_PIXELS`, 640: pixels per line; must be a multiple of 4. Words per line: `X_WORDS = X_PIXELS*3/4` (480).
- `Y_SIZE`, 480: lines per frame.
- `out_stream_aclk`  in  1  sole clock; all logic on rising edge.
- `periph_reset`  in  1  asynchronous, active-high reset.
- `in_pixel_tdata`  in  24  pixel, `{R[23:16], G[15:8], B[7:0]}`.
- `in_pixel_tvalid`  in  1  source has a pixel.
- `in_pixel_tuser`  in  1  pixel is the first of a frame (resync).
- `in_pixel_tready`  out  1  packer accepts the pixel this cycle.
- `out_stream_tdata`  out  32  packed word.
- `out_stream_tkeep`  out  4  constant `4'hF`.
- `out_stream_tvalid`  out  1  word valid.
- `out_stream_tready`  in  1  sink accepts the word.
- `out_stream_tuser`  out  1  SOF, first word of frame.
- `out_stream_tlast`  out  1  EOL, last word of line.

## Operation
- Pixel accepted when `in_pixel_tvalid && in_pixel_tready`. Word transferred when `out_stream_tvalid && out_stream_tready`.
- `phase` (0..3) counts accepted pixels in the current group; `res` holds up to 24 residual bits.
  - phase 0: `res <= p[23:0]`; no word emitted.
  - phase 1: emit `{p[7:0], res[23:0]}`; `res <= p[23:8]`.
  - phase 2: emit `{p[15:0], res[15:0]}`; `res <= p[23:16]`.
  - phase 3: emit `{p[23:0], res[7:0]}`; phase → 0.
- Word counters `x` (0..X_WORDS-1) and `y` (0..Y_SIZE-1) advance on each word *loaded* into the output register. `tuser = (x==0 && y==0)`, `tlast = (x==X_WORDS-1)`, both registered alongside the data. `x` wraps to 0 and increments `y`; `y` wraps from Y_SIZE-1 to 0. Phase is always 0 at a line boundary because X_PIXELS is a multiple of 4.
- Resync: an accepted pixel with `in_pixel_tuser=1` forces phase 0, discards `res`, and sets `x=0, y=0` before processing it. The next emitted word carries `tuser=1`. A word already in the output register is still delivered unchanged.
- An accepted `tuser` pixel at natural frame start (phase 0, x=0, y=0) is a no-op resync.

## Timing
- Reset values: `tvalid=0`, `tdata=0`, `tuser=0`, `tlast=0`, `tkeep=4'hF`, `phase=0`, `x=0`, `y=0`, `res=0`. Reset mid-frame drops any partial group and any held word.
- `in_pixel_tready = (phase==0 && !tuser_pending_resync_irrelevant) || !out_stream_tvalid || out_stream_tready`. Simplified rule: ready when phase 0, or the output register is empty or draining this cycle. Combinational from `out_stream_tready` and registered state only.
- Latency: a word appears on `out_stream_tvalid` 1 cycle after the pixel that completes it is accepted.
- While `tvalid && !tready`, `tdata`, `tuser`, and `tlast` are held stable. `tvalid` never drops without a transfer.
- Throughput: with `out_stream_tready=1` constantly, 1 pixel/cycle in and 3 words per 4 cycles out, with no bubbles on input.
- Accept and drain in the same cycle: the register reloads and `tvalid` stays 1.

## Structure
- Shared package `video_stream_pkg`: `PIXEL_W=24`, `WORD_W=32`, the default X_PIXELS/Y_SIZE, and the `tkeep` constant.
- Single module. No sub-module is required; the output register may optionally be a `axis_out_reg` instance (data+user+last, valid/ready).

## Test plan
- Always-ready sink, pixels `0x000001..` incrementing: word0 = `0x02000001`, word1 = `0x00030000`, word2 = `0x00000400`. 480 words per line, `tlast` only on word 479, `tuser` only on word 0 of each frame, 3 frames clean.
- Random 50% `out_stream_tready` (PRBS seed 1246504138): stream is identical to the always-ready case, and data/flags are stable while stalled.
- Ready-after-valid sink (ready pulses one cycle after valid): no words are lost or duplicated, and the input stalls only in phases 1–3.
- `in_pixel_tuser` asserted at pixel 2 of line 5: the partial group is discarded, the next word has `tuser=1` and x=0, and a full frame follows.
- `periph_reset` pulsed mid-line while a word is stalled: all outputs go to their reset values immediately, and the first word after release has `tuser=1`.
- X_PIXELS=8, Y_SIZE=2: `tlast` on every 6th word, `tuser` on every 12th word.

Source files
------------

// File: rtl/video_stream_pkg.sv
// Shared video stream types and constants.
// Pixel/word widths, default raster size, packer phase.
package video_stream_pkg;

  localparam int PIXEL_W      = 24;
  localparam int WORD_W       = 32;
  localparam int X_PIXELS_DEF = 640;
  localparam int Y_SIZE_DEF   = 480;

  localparam logic [3:0] TKEEP = 4'hF;

  typedef enum logic [1:0] {
    PH0,
    PH1,
    PH2,
    PH3
  } phase_t;

endpackage

// File: rtl/pixel_stream_packer_out_reg.sv
// AXI-Stream output register: data, user, last.
// Holds its contents until the sink takes them.
import video_stream_pkg::*;

module axis_out_reg (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] ld_data,
  input  logic              ld_user,
  input  logic              ld_last,
  input  logic              tready,
  output logic              tvalid,
  output logic [WORD_W-1:0] tdata,
  output logic              tuser,
  output logic              tlast
);

  // load new word, or drop valid once the sink has taken it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tvalid <= 1'b0;
      tdata  <= '0;
      tuser  <= 1'b0;
      tlast  <= 1'b0;
    end else if (load) begin
      tvalid <= 1'b1;
      tdata  <= ld_data;
      tuser  <= ld_user;
      tlast  <= ld_last;
    end else if (tready) begin
      tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/pixel_stream_packer.sv
// Packs 24-bit pixels into 32-bit words (4 px -> 3 words)
// and tags frame start (tuser) and line end (tlast).
import video_stream_pkg::*;

module pixel_stream_packer #(
  parameter int X_PIXELS = X_PIXELS_DEF,
  parameter int Y_SIZE   = Y_SIZE_DEF
) (
  input  logic        out_stream_aclk,
  input  logic        periph_reset,
  input  logic [23:0] in_pixel_tdata,
  input  logic        in_pixel_tvalid,
  input  logic        in_pixel_tuser,
  output logic        in_pixel_tready,
  output logic [31:0] out_stream_tdata,
  output logic [3:0]  out_stream_tkeep,
  output logic        out_stream_tvalid,
  input  logic        out_stream_tready,
  output logic        out_stream_tuser,
  output logic        out_stream_tlast
);

  localparam int X_WORDS = X_PIXELS * 3 / 4;
  localparam int XW = (X_WORDS > 1) ? $clog2(X_WORDS) : 1;
  localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  localparam logic [XW-1:0] XLAST = XW'(X_WORDS - 1);
  localparam logic [YW-1:0] YLAST = YW'(Y_SIZE - 1);

  phase_t        phase, phase_n, ph_e;
  logic [23:0]   res, res_n;
  logic [XW-1:0] x, x_n, x_e;
  logic [YW-1:0] y, y_n, y_e;

  logic          accept;
  logic          load;
  logic [31:0]   ld_data;
  logic          ld_user;
  logic          ld_last;
  logic [23:0]   p;

  assign p = in_pixel_tdata;
  assign out_stream_tkeep = TKEEP;

  // phase 0 never emits, so it can always take a pixel
  assign in_pixel_tready = (phase == PH0)
                        || !out_stream_tvalid
                        || out_stream_tready;

  assign accept = in_pixel_tvalid && in_pixel_tready;

  // next group state, word assembly and raster position
  always_comb begin
    ph_e    = in_pixel_tuser ? PH0 : phase;
    x_e     = in_pixel_tuser ? '0 : x;
    y_e     = in_pixel_tuser ? '0 : y;
    phase_n = phase;
    res_n   = res;
    x_n     = x;
    y_n     = y;
    load    = 1'b0;
    ld_data = '0;
    ld_user = 1'b0;
    ld_last = 1'b0;
    if (accept) begin
      x_n = x_e;
      y_n = y_e;
      unique case (ph_e)
        PH0: begin
          res_n   = p;
          phase_n = PH1;
        end
        PH1: begin
          load    = 1'b1;
          ld_data = {p[7:0], res};
          res_n   = {8'h00, p[23:8]};
          phase_n = PH2;
        end
        PH2: begin
          load    = 1'b1;
          ld_data = {p[15:0], res[15:0]};
          res_n   = {16'h0000, p[23:16]};
          phase_n = PH3;
        end
        PH3: begin
          load    = 1'b1;
          ld_data = {p, res[7:0]};
          res_n   = '0;
          phase_n = PH0;
        end
      endcase
      if (load) begin
        ld_user = (x_e == '0) && (y_e == '0);
        ld_last = (x_e == XLAST);
        if (x_e == XLAST) begin
          x_n = '0;
          y_n = (y_e == YLAST) ? '0 : y_e + YW'(1);
        end else begin
          x_n = x_e + XW'(1);
        end
      end
    end
  end

  // group phase, residual bytes and word position
  always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
    if (periph_reset) begin
      phase <= PH0;
      res   <= '0;
      x     <= '0;
      y     <= '0;
    end else begin
      phase <= phase_n;
      res   <= res_n;
      x     <= x_n;
      y     <= y_n;
    end
  end

  axis_out_reg u_out (
    .clk     (out_stream_aclk),
    .rst     (periph_reset),
    .load    (load),
    .ld_data (ld_data),
    .ld_user (ld_user),
    .ld_last (ld_last),
    .tready  (out_stream_tready),
    .tvalid  (out_stream_tvalid),
    .tdata   (out_stream_tdata),
    .tuser   (out_stream_tuser),
    .tlast   (out_stream_tlast)
  );

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Bench for pixel_stream_packer on a small 8x6 raster.
// Byte-queue reference model; random data and sink stalls.
module tb_pixel_stream_packer;

  localparam int XPIX = 8;
  localparam int YS   = 6;
  localparam int XWD  = XPIX * 3 / 4;
  localparam int FW   = XWD * YS;

  logic        out_stream_aclk;
  logic        periph_reset;
  logic [23:0] in_pixel_tdata;
  logic        in_pixel_tvalid;
  logic        in_pixel_tuser;
  logic        in_pixel_tready;
  logic [31:0] out_stream_tdata;
  logic [3:0]  out_stream_tkeep;
  logic        out_stream_tvalid;
  logic        out_stream_tready;
  logic        out_stream_tuser;
  logic        out_stream_tlast;

  pixel_stream_packer #(.X_PIXELS(XPIX), .Y_SIZE(YS)) dut (
    .out_stream_aclk   (out_stream_aclk),
    .periph_reset      (periph_reset),
    .in_pixel_tdata    (in_pixel_tdata),
    .in_pixel_tvalid   (in_pixel_tvalid),
    .in_pixel_tuser    (in_pixel_tuser),
    .in_pixel_tready   (in_pixel_tready),
    .out_stream_tdata  (out_stream_tdata),
    .out_stream_tkeep  (out_stream_tkeep),
    .out_stream_tvalid (out_stream_tvalid),
    .out_stream_tready (out_stream_tready),
    .out_stream_tuser  (out_stream_tuser),
    .out_stream_tlast  (out_stream_tlast)
  );

  initial out_stream_aclk = 1'b0;
  always #5 out_stream_aclk = ~out_stream_aclk;

  typedef struct packed {
    logic [31:0] d;
    logic        u;
    logic        l;
  } wexp_t;

  logic [7:0]  bq[$];
  wexp_t       exp_q[$];
  logic [31:0] got_d[$];
  logic        got_u[$];
  logic        got_l[$];
  int          wk;
  int          pcnt;
  int          total;
  int          bad;
  int          stalls;
  int          ph0_stalls;
  logic [23:0] seq;

  // raster model: pixels become a little-endian byte stream
  function automatic void model_accept(logic [23:0] p, logic u);
    wexp_t w;
    if (u) begin
      bq.delete();
      wk   = 0;
      pcnt = 0;
    end
    bq.push_back(p[7:0]);
    bq.push_back(p[15:8]);
    bq.push_back(p[23:16]);
    pcnt++;
    while (bq.size() >= 4) begin
      w.d = {bq[3], bq[2], bq[1], bq[0]};
      repeat (4) void'(bq.pop_front());
      w.u = (wk % FW) == 0;
      w.l = (wk % XWD) == XWD - 1;
      exp_q.push_back(w);
      wk++;
    end
  endfunction

  function automatic void model_clear();
    bq.delete();
    exp_q.delete();
    wk   = 0;
    pcnt = 0;
  endfunction

  task automatic do_reset();
    in_pixel_tvalid   = 1'b0;
    in_pixel_tuser    = 1'b0;
    in_pixel_tdata    = '0;
    out_stream_tready = 1'b0;
    periph_reset      = 1'b1;
    repeat (2) @(posedge out_stream_aclk);
    #1 periph_reset = 1'b0;
    model_clear();
  endtask

  // mode 0: always ready, 1: random, 2: ready one cycle after valid
  task automatic stream(input int npix, input int mode,
                        input int rs_at, input bit rnd,
                        input int gap);
    int          sent   = 0;
    int          cyc    = 0;
    int          budget = npix * 8 + 200;
    logic [23:0] cur;
    bit          acc    = 0;
    bit          held   = 0;
    bit          vseen  = 0;
    logic [31:0] hd     = '0;
    logic        hu     = 0;
    logic        hl     = 0;
    wexp_t       e;
    got_d.delete();
    got_u.delete();
    got_l.delete();
    stalls     = 0;
    ph0_stalls = 0;
    if (rnd) cur = 24'($urandom);
    else begin cur = seq; seq = seq + 1; end
    while ((sent < npix || exp_q.size() != 0)
           && cyc < budget) begin
      @(posedge out_stream_aclk);
      #1;
      cyc++;
      if (acc) begin
        sent++;
        if (rnd) cur = 24'($urandom);
        else begin cur = seq; seq = seq + 1; end
      end
      in_pixel_tvalid = (sent < npix)
                     && ($urandom_range(99) >= gap);
      in_pixel_tdata  = cur;
      in_pixel_tuser  = (sent == rs_at);
      case (mode)
        0: out_stream_tready = 1'b1;
        1: out_stream_tready = 1'($urandom % 2);
        default:
          out_stream_tready = vseen && !out_stream_tready;
      endcase
      @(negedge out_stream_aclk);
      if (held) begin
        total++;
        if ({out_stream_tvalid, out_stream_tdata,
             out_stream_tuser, out_stream_tlast}
            !== {1'b1, hd, hu, hl}) begin
          bad++;
          $display("FAIL hold: got v=%0b d=%h u=%0b l=%0b want d=%h u=%0b l=%0b",
                   out_stream_tvalid, out_stream_tdata,
                   out_stream_tuser, out_stream_tlast, hd, hu, hl);
        end
      end
      if (in_pixel_tvalid && !in_pixel_tready) begin
        stalls++;
        if (pcnt % 4 == 0) ph0_stalls++;
      end
      acc = in_pixel_tvalid && in_pixel_tready;
      if (acc) model_accept(cur, in_pixel_tuser);
      if (out_stream_tvalid && out_stream_tready) begin
        total++;
        got_d.push_back(out_stream_tdata);
        got_u.push_back(out_stream_tuser);
        got_l.push_back(out_stream_tlast);
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_word: got d=%h want none",
                   out_stream_tdata);
        end else begin
          e = exp_q.pop_front();
          if ({out_stream_tdata, out_stream_tuser,
               out_stream_tlast} !== {e.d, e.u, e.l}) begin
            bad++;
            $display("FAIL word%0d: got d=%h u=%0b l=%0b want d=%h u=%0b l=%0b",
                     got_d.size() - 1, out_stream_tdata,
                     out_stream_tuser, out_stream_tlast,
                     e.d, e.u, e.l);
          end
        end
      end
      held  = out_stream_tvalid && !out_stream_tready;
      hd    = out_stream_tdata;
      hu    = out_stream_tuser;
      hl    = out_stream_tlast;
      vseen = out_stream_tvalid;
    end
    total++;
    if (cyc >= budget) begin
      bad++;
      $display("FAIL timeout: got sent=%0d left=%0d want sent=%0d left=0",
               sent, exp_q.size(), npix);
    end
    @(posedge out_stream_aclk);
    #1;
    in_pixel_tvalid   = 1'b0;
    in_pixel_tuser    = 1'b0;
    out_stream_tready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge out_stream_aclk);
    total++;
    if ({out_stream_tvalid, out_stream_tdata, out_stream_tuser,
         out_stream_tlast, out_stream_tkeep, in_pixel_tready}
        !== {1'b0, 32'h0, 1'b0, 1'b0, 4'hF, 1'b1}) begin
      bad++;
      $display("FAIL reset: got v=%0b d=%h u=%0b l=%0b k=%h r=%0b want 0 0 0 0 f 1",
               out_stream_tvalid, out_stream_tdata,
               out_stream_tuser, out_stream_tlast,
               out_stream_tkeep, in_pixel_tready);
    end
  endtask

  task automatic test_basic();
    int nl = 0;
    int nu = 0;
    seq = 24'h000001;
    stream(144, 0, -1, 0, 0);
    total++;
    if (got_d.size() != 108) begin
      bad++;
      $display("FAIL basic_count: got %0d want 108", got_d.size());
    end else begin
      total++;
      if ({got_d[0], got_d[1], got_d[2]}
          !== {32'h02000001, 32'h00030000, 32'h00000400}) begin
        bad++;
        $display("FAIL basic_first: got %h %h %h want 02000001 00030000 00000400",
                 got_d[0], got_d[1], got_d[2]);
      end
      foreach (got_l[i]) if (got_l[i]) nl++;
      foreach (got_u[i]) if (got_u[i]) nu++;
      total++;
      if (nl != 18 || nu != 3) begin
        bad++;
        $display("FAIL basic_flags: got last=%0d user=%0d want 18 3",
                 nl, nu);
      end
    end
    total++;
    if (stalls != 0) begin
      bad++;
      $display("FAIL basic_throughput: got stalls=%0d want 0", stalls);
    end
    total++;
    if (out_stream_tkeep !== 4'hF) begin
      bad++;
      $display("FAIL tkeep: got %h want f", out_stream_tkeep);
    end
  endtask

  task automatic test_random_ready();
    stream(144, 1, -1, 1, 0);
    total++;
    if (got_d.size() != 108) begin
      bad++;
      $display("FAIL rand_count: got %0d want 108", got_d.size());
    end
    stream(100, 1, -1, 1, 30);
    total++;
    if (got_d.size() != 75) begin
      bad++;
      $display("FAIL gap_count: got %0d want 75", got_d.size());
    end
  endtask

  task automatic test_ready_after_valid();
    stream(96, 2, -1, 1, 0);
    total++;
    if (ph0_stalls != 0 || stalls == 0) begin
      bad++;
      $display("FAIL rav_stall: got ph0=%0d all=%0d want ph0=0 all>0",
               ph0_stalls, stalls);
    end
  endtask

  task automatic test_resync();
    do_reset();
    stream(90, 0, 42, 1, 0);
    total++;
    if (got_d.size() != 67) begin
      bad++;
      $display("FAIL resync_count: got %0d want 67", got_d.size());
    end else begin
      total++;
      if ({got_u[30], got_u[31], got_l[36]} !== 3'b011) begin
        bad++;
        $display("FAIL resync_flags: got u30=%0b u31=%0b l36=%0b want 0 1 1",
                 got_u[30], got_u[31], got_l[36]);
      end
    end
  endtask

  task automatic test_midreset();
    do_reset();
    @(posedge out_stream_aclk);
    #1;
    in_pixel_tvalid = 1'b1;
    in_pixel_tdata  = 24'h111111;
    @(posedge out_stream_aclk);
    #1 in_pixel_tdata = 24'h222222;
    @(posedge out_stream_aclk);
    #1 in_pixel_tdata = 24'h333333;
    @(negedge out_stream_aclk);
    total++;
    if ({out_stream_tvalid, in_pixel_tready} !== 2'b10) begin
      bad++;
      $display("FAIL stall_setup: got v=%0b r=%0b want 1 0",
               out_stream_tvalid, in_pixel_tready);
    end
    #2 periph_reset = 1'b1;
    #1;
    total++;
    if ({out_stream_tvalid, out_stream_tdata, out_stream_tuser,
         out_stream_tlast, in_pixel_tready}
        !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL async_reset: got v=%0b d=%h u=%0b l=%0b r=%0b want 0 0 0 0 1",
               out_stream_tvalid, out_stream_tdata,
               out_stream_tuser, out_stream_tlast, in_pixel_tready);
    end
    in_pixel_tvalid = 1'b0;
    @(posedge out_stream_aclk);
    #1 periph_reset = 1'b0;
    model_clear();
    stream(8, 0, -1, 1, 0);
    total++;
    if (got_u.size() != 6 || got_u[0] !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_sof: got n=%0d want n=6 with tuser on word 0",
               got_u.size());
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    seq   = 24'h000001;
    void'($urandom(1246504138));
    test_reset();
    test_basic();
    test_random_ready();
    test_ready_after_valid();
    test_resync();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
